mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Owns the single byte-wide unified memory of the multicycle MIPS8 core and shares it between three requesters: a boot loader byte stream, the CPU, and a debug port. After reset it holds the CPU in reset while BOOT_LEN bytes are streamed into addresses 0..BOOT_LEN-1. It then releases the CPU, gives the CPU strict priority, and serves debug accesses in idle memory cycles. It sits between the CPU datapath (memory address, write data, controller memread/memwrite) and the memory macro.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- BOOT_LEN, 64, bytes loaded at boot; legal range 1..2^ADDR_W
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- boot_valid  in  1  boot byte present
- boot_data  in  DATA_W  boot byte
- boot_ready  out  1  boot byte accepted this cycle when high with boot_valid
- boot_done  out  1  boot load complete (sticky until reset)
- cpu_reset  out  1  reset to CPU core
- cpu_memread  in  1  CPU read request (from controller)
- cpu_memwrite  in  1  CPU write request (from controller)
- cpu_adr  in  ADDR_W  CPU address (after iord mux)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU
- dbg_req  in  1  debug access request
- dbg_we  in  1  debug write (1) / read (0)
- dbg_adr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rdata  out  DATA_W  registered debug read data
- dbg_rvalid  out  1  dbg_rdata valid
- mem_adr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data (combinational read)

## Operation
- States: BOOT, RELEASE, RUN.
- Reset cycle: state<=BOOT, boot counter<=0, boot_done<=0, dbg_rvalid<=0, dbg_rdata<=0. While reset is high, outputs are: cpu_reset=1, boot_ready=0, dbg_gnt=0, mem_we=0, mem_adr=0, mem_wdata=0.
- BOOT:
  - boot_ready=1 and cpu_reset=1.
  - On boot_valid: mem_adr=counter, mem_wdata=boot_data, mem_we=1, counter++.
  - Accepting byte BOOT_LEN-1 moves the state to RELEASE.
  - No CPU or debug access: dbg_gnt=0 and CPU requests are ignored.
- RELEASE (exactly 1 cycle):
  - cpu_reset=1, boot_ready=0, no memory access.
  - boot_done<=1, then go to RUN.
- RUN:
  - cpu_reset=0, boot_ready=0.
  - If cpu_memread|cpu_memwrite: mem_adr=cpu_adr, mem_wdata=cpu_wdata, mem_we=cpu_memwrite, dbg_gnt=0.
  - Else if dbg_req: dbg_gnt=1, mem_adr=dbg_adr, mem_wdata=dbg_wdata, mem_we=dbg_we.
  - Else mem_we=0 and mem_adr=cpu_adr.
- cpu_rdata=mem_rdata at all times.
- Debug read: on a granted read, dbg_rdata<=mem_rdata and dbg_rvalid<=1 for one cycle. dbg_rvalid is 0 in every other cycle.
- The debug requester holds dbg_req and its fields stable until it sees dbg_gnt. It may starve indefinitely under continuous CPU traffic; this is accepted.
- Counter width is ADDR_W+1. BOOT_LEN=2^ADDR_W fills the whole memory with no address wrap.
- Reset in any state, including mid-boot, restarts at BOOT with counter 0. Previously written bytes remain in memory and are overwritten by the new load.

## Timing
- Boot write latency: 0 cycles; the byte is written in its accept cycle.
- cpu_reset falls 2 cycles after the final boot byte is accepted: byte cycle, then the RELEASE cycle. The CPU's first fetch is in the following cycle.
- CPU access latency: 0 added cycles; the memory path is combinational from the cpu_* inputs.
- dbg_gnt is combinational in the request cycle. dbg_rvalid and dbg_rdata appear 1 cycle after a granted read.
- Simultaneous CPU and debug requests: the CPU wins and debug waits. Back-to-back debug grants are allowed every idle cycle.

## Structure
- Shared package mips8_mem_pkg holds the arb_state_t enum {BOOT, RELEASE, RUN} and the default BOOT_LEN constant.
- Single module, no sub-modules. Next-state and mux logic are combinational; state, counter, boot_done and debug read registers are sequential.

## Test plan
- Boot, BOOT_LEN=4, bytes 0x11,0x22,0x33,0x44 with one idle (boot_valid=0) gap after byte 2 -> mem[0..3] = those bytes; cpu_reset=1 until the RELEASE cycle; boot_done=1 and cpu_reset=0 on the next cycle.
- After boot, CPU writes 0x5A to 0x20 -> mem_we=1, mem_adr=0x20. CPU reads 0x20 -> cpu_rdata=0x5A in the same cycle.
- CPU memread and dbg_req (read 0x01) in the same cycle -> dbg_gnt=0. Next cycle, CPU idle -> dbg_gnt=1; the cycle after, dbg_rvalid=1 and dbg_rdata=0x22.
- dbg_req asserted during BOOT -> dbg_gnt=0 throughout BOOT and RELEASE; the first grant comes in the first idle RUN cycle.
- Reset after 2 of 4 boot bytes, then stream 0xA0..0xA3 -> mem[0..3]=0xA0..0xA3, boot_done=0 until the new load completes.
- BOOT_LEN=2^ADDR_W (256) full load -> last byte lands at 0xFF, no wrap to 0x00, RELEASE reached exactly once.

Source files
------------

// File: rtl/mips8_mem_pkg.sv
// Shared types and constants for the MIPS8 unified-memory arbiter.
package mips8_mem_pkg;
   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } arb_state_t;

   localparam int DEFAULT_BOOT_LEN = 64;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and the memory macro.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              boot_valid;
   logic [DATA_W-1:0] boot_data;
   logic              boot_ready;
   logic              boot_done;
   logic              cpu_reset;
   logic              cpu_memread;
   logic              cpu_memwrite;
   logic [ADDR_W-1:0] cpu_adr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_adr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_rvalid;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  boot_valid, boot_data,
      input  cpu_memread, cpu_memwrite, cpu_adr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
      input  mem_rdata,
      output boot_ready, boot_done, cpu_reset, cpu_rdata,
      output dbg_gnt, dbg_rdata, dbg_rvalid,
      output mem_adr, mem_wdata, mem_we
   );

   modport master (
      output boot_valid, boot_data,
      output cpu_memread, cpu_memwrite, cpu_adr, cpu_wdata,
      output dbg_req, dbg_we, dbg_adr, dbg_wdata,
      output mem_rdata,
      input  boot_ready, boot_done, cpu_reset, cpu_rdata,
      input  dbg_gnt, dbg_rdata, dbg_rvalid,
      input  mem_adr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the MIPS8 unified memory between the boot loader, the CPU and a debug port.
// Boot load first (CPU held in reset), then CPU has strict priority and debug fills idle cycles.
module mem_arbiter
   import mips8_mem_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int BOOT_LEN = DEFAULT_BOOT_LEN
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   // One extra counter bit lets BOOT_LEN cover the full address space without wrapping.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(BOOT_LEN - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   arb_state_t        state_r;
   arb_state_t        state_nxt_s;
   logic [ADDR_W:0]   cnt_r;
   logic              boot_done_r;
   logic              dbg_rvalid_r;
   logic [DATA_W-1:0] dbg_rdata_r;

   logic              boot_take_s;
   logic              boot_ready_s;
   logic              cpu_reset_s;
   logic              dbg_gnt_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_adr_s;
   logic [DATA_W-1:0] mem_wdata_s;

   // Next-state selection and memory port multiplexing
   always_comb begin
      state_nxt_s  = state_r;
      boot_take_s  = 1'b0;
      boot_ready_s = 1'b0;
      cpu_reset_s  = 1'b1;
      dbg_gnt_s    = 1'b0;
      mem_we_s     = 1'b0;
      mem_adr_s    = {ADDR_W{1'b0}};
      mem_wdata_s  = {DATA_W{1'b0}};
      if (reset) begin
         state_nxt_s = BOOT;
      end else begin
         case (state_r)
            BOOT: begin
               boot_ready_s = 1'b1;
               if (bus.boot_valid) begin
                  boot_take_s = 1'b1;
                  mem_we_s    = 1'b1;
                  mem_adr_s   = cnt_r[ADDR_W-1:0];
                  mem_wdata_s = bus.boot_data;
                  if (cnt_r == LAST_IDX) begin
                     state_nxt_s = RELEASE;
                  end else begin
                     state_nxt_s = BOOT;
                  end
               end else begin
                  state_nxt_s = BOOT;
               end
            end
            RELEASE: begin
               state_nxt_s = RUN;
            end
            RUN: begin
               cpu_reset_s = 1'b0;
               state_nxt_s = RUN;
               if (bus.cpu_memread || bus.cpu_memwrite) begin
                  mem_adr_s   = bus.cpu_adr;
                  mem_wdata_s = bus.cpu_wdata;
                  mem_we_s    = bus.cpu_memwrite;
               end else if (bus.dbg_req) begin
                  // Debug only gets cycles the CPU leaves idle.
                  dbg_gnt_s   = 1'b1;
                  mem_adr_s   = bus.dbg_adr;
                  mem_wdata_s = bus.dbg_wdata;
                  mem_we_s    = bus.dbg_we;
               end else begin
                  mem_adr_s   = bus.cpu_adr;
                  mem_wdata_s = bus.cpu_wdata;
               end
            end
            default: begin
               state_nxt_s = BOOT;
            end
         endcase
      end
   end

   // State register, boot byte counter and sticky boot_done flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= BOOT;
         cnt_r       <= {(ADDR_W + 1){1'b0}};
         boot_done_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (boot_take_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (state_r == RELEASE) begin
            boot_done_r <= 1'b1;
         end
      end
   end

   // Debug read capture, valid for exactly one cycle after a granted read
   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_rvalid_r <= 1'b0;
         dbg_rdata_r  <= {DATA_W{1'b0}};
      end else if (dbg_gnt_s && !bus.dbg_we) begin
         dbg_rvalid_r <= 1'b1;
         dbg_rdata_r  <= bus.mem_rdata;
      end else begin
         dbg_rvalid_r <= 1'b0;
      end
   end

   assign bus.boot_ready = boot_ready_s;
   assign bus.boot_done  = boot_done_r;
   assign bus.cpu_reset  = cpu_reset_s;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dbg_gnt    = dbg_gnt_s;
   assign bus.dbg_rdata  = dbg_rdata_r;
   assign bus.dbg_rvalid = dbg_rvalid_r;
   assign bus.mem_adr    = mem_adr_s;
   assign bus.mem_wdata  = mem_wdata_s;
   assign bus.mem_we     = mem_we_s;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: per-cycle reference model for a BOOT_LEN=4 instance plus a full 256-byte load instance.
module tb_mem_arbiter;
   localparam int BL_A = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a;
   logic reset_b;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .BOOT_LEN(BL_A)) dut_a (
      .clk(clk), .reset(reset_a), .bus(bus_a.slave));
   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .BOOT_LEN(256)) dut_b (
      .clk(clk), .reset(reset_b), .bus(bus_b.slave));

   // Memory macros: combinational read, clocked write
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   assign bus_a.mem_rdata = mem_a[bus_a.mem_adr];
   assign bus_b.mem_rdata = mem_b[bus_b.mem_adr];
   always @(posedge clk) if (bus_a.mem_we === 1'b1) mem_a[bus_a.mem_adr] <= bus_a.mem_wdata;
   always @(posedge clk) if (bus_b.mem_we === 1'b1) mem_b[bus_b.mem_adr] <= bus_b.mem_wdata;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state for instance A
   logic [7:0] ref_mem [256];
   bit         chk_on = 1'b0;
   int         m_bytes = 0;
   bit         m_released = 1'b0;
   bit         m_done = 1'b0;
   bit         m_rv = 1'b0;
   logic [7:0] m_rd = 8'h00;
   logic       e_cr, e_br, e_g, e_we, cpu_req;
   logic [7:0] e_adr, e_wd;
   bit         c_adr, c_wd, c_rd;

   always @(negedge clk) begin
      if (chk_on) begin
         e_cr = 1'b1; e_br = 1'b0; e_g = 1'b0; e_we = 1'b0;
         e_adr = 8'h00; e_wd = 8'h00;
         c_adr = 1'b0; c_wd = 1'b0; c_rd = 1'b0;
         cpu_req = bus_a.cpu_memread | bus_a.cpu_memwrite;
         if (reset_a) begin
            c_adr = 1'b1; c_wd = 1'b1;
         end else if (m_bytes < BL_A) begin
            e_br = 1'b1;
            if (bus_a.boot_valid) begin
               e_we = 1'b1; e_adr = 8'(m_bytes); e_wd = bus_a.boot_data;
               c_adr = 1'b1; c_wd = 1'b1;
            end
         end else if (m_released) begin
            e_cr = 1'b0;
            if (cpu_req) begin
               e_we = bus_a.cpu_memwrite; e_adr = bus_a.cpu_adr; e_wd = bus_a.cpu_wdata;
               c_adr = 1'b1; c_wd = 1'b1; c_rd = bus_a.cpu_memread;
            end else if (bus_a.dbg_req) begin
               e_g = 1'b1; e_we = bus_a.dbg_we; e_adr = bus_a.dbg_adr; e_wd = bus_a.dbg_wdata;
               c_adr = 1'b1; c_wd = 1'b1;
            end else begin
               e_adr = bus_a.cpu_adr; c_adr = 1'b1;
            end
         end
         chk("m_cpu_reset", 32'(bus_a.cpu_reset), 32'(e_cr));
         chk("m_boot_ready", 32'(bus_a.boot_ready), 32'(e_br));
         chk("m_dbg_gnt", 32'(bus_a.dbg_gnt), 32'(e_g));
         chk("m_mem_we", 32'(bus_a.mem_we), 32'(e_we));
         chk("m_boot_done", 32'(bus_a.boot_done), 32'(m_done));
         chk("m_dbg_rvalid", 32'(bus_a.dbg_rvalid), 32'(m_rv));
         if (c_adr) chk("m_mem_adr", 32'(bus_a.mem_adr), 32'(e_adr));
         if (c_wd) chk("m_mem_wdata", 32'(bus_a.mem_wdata), 32'(e_wd));
         if (c_rd) chk("m_cpu_rdata", 32'(bus_a.cpu_rdata), 32'(ref_mem[bus_a.cpu_adr]));
         if (m_rv) chk("m_dbg_rdata", 32'(bus_a.dbg_rdata), 32'(m_rd));
         // Advance the model across the coming clock edge
         if (reset_a) begin
            m_bytes = 0; m_released = 1'b0; m_done = 1'b0; m_rv = 1'b0; m_rd = 8'h00;
         end else if (m_bytes < BL_A) begin
            m_rv = 1'b0;
            if (bus_a.boot_valid) begin
               ref_mem[m_bytes] = bus_a.boot_data;
               m_bytes++;
            end
         end else if (!m_released) begin
            m_released = 1'b1; m_done = 1'b1; m_rv = 1'b0;
         end else begin
            m_rv = e_g && !bus_a.dbg_we;
            if (m_rv) m_rd = ref_mem[bus_a.dbg_adr];
            if (e_we) ref_mem[e_adr] = e_wd;
         end
      end
   end

   // Instance B observers: RELEASE cycles and writes to address 0
   int rel_b = 0;
   int wr0_b = 0;
   always @(negedge clk) begin
      if (reset_b === 1'b0 && bus_b.cpu_reset === 1'b1 && bus_b.boot_ready === 1'b0) rel_b++;
      if (reset_b === 1'b0 && bus_b.mem_we === 1'b1 && bus_b.mem_adr === 8'h00) wr0_b++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic boot_a(input logic [7:0] d);
      bus_a.boot_valid = 1'b1;
      bus_a.boot_data  = d;
      neg();
      chk("boot_cpu_reset", 32'(bus_a.cpu_reset), 32'd1);
      chk("boot_done_low", 32'(bus_a.boot_done), 32'd0);
      cyc();
      bus_a.boot_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'h00; mem_b[i] = 8'h00; ref_mem[i] = 8'h00;
      end
      reset_a = 1'b1; reset_b = 1'b1;
      bus_a.boot_valid = 1'b0; bus_a.boot_data = 8'h00;
      bus_a.cpu_memread = 1'b0; bus_a.cpu_memwrite = 1'b0;
      bus_a.cpu_adr = 8'h00; bus_a.cpu_wdata = 8'h00;
      bus_a.dbg_req = 1'b0; bus_a.dbg_we = 1'b0; bus_a.dbg_adr = 8'h00; bus_a.dbg_wdata = 8'h00;
      bus_b.boot_valid = 1'b0; bus_b.boot_data = 8'h00;
      bus_b.cpu_memread = 1'b0; bus_b.cpu_memwrite = 1'b0;
      bus_b.cpu_adr = 8'h00; bus_b.cpu_wdata = 8'h00;
      bus_b.dbg_req = 1'b0; bus_b.dbg_we = 1'b0; bus_b.dbg_adr = 8'h00; bus_b.dbg_wdata = 8'h00;

      cyc();
      chk_on = 1'b1;
      neg();
      chk("rst_dbg_rdata", 32'(bus_a.dbg_rdata), 32'd0);
      chk("rst_mem_adr", 32'(bus_a.mem_adr), 32'd0);
      cyc();

      // Boot 4 bytes with a gap after byte 2; debug read of 0x03 pending throughout
      reset_a = 1'b0;
      bus_a.dbg_req = 1'b1; bus_a.dbg_we = 1'b0; bus_a.dbg_adr = 8'h03;
      boot_a(8'h11);
      boot_a(8'h22);
      neg(); chk("gap_dbg_gnt", 32'(bus_a.dbg_gnt), 32'd0); cyc();
      boot_a(8'h33);
      boot_a(8'h44);
      neg();
      chk("rel_cpu_reset", 32'(bus_a.cpu_reset), 32'd1);
      chk("rel_dbg_gnt", 32'(bus_a.dbg_gnt), 32'd0);
      chk("mem0", 32'(mem_a[0]), 32'h11);
      chk("mem1", 32'(mem_a[1]), 32'h22);
      chk("mem2", 32'(mem_a[2]), 32'h33);
      chk("mem3", 32'(mem_a[3]), 32'h44);
      cyc();
      neg();
      chk("run_cpu_reset", 32'(bus_a.cpu_reset), 32'd0);
      chk("run_boot_done", 32'(bus_a.boot_done), 32'd1);
      chk("first_idle_gnt", 32'(bus_a.dbg_gnt), 32'd1);
      cyc();

      // CPU write, then same-cycle read-back
      bus_a.dbg_req = 1'b0;
      bus_a.cpu_memwrite = 1'b1; bus_a.cpu_adr = 8'h20; bus_a.cpu_wdata = 8'h5A;
      neg();
      chk("cpu_wr_we", 32'(bus_a.mem_we), 32'd1);
      chk("cpu_wr_adr", 32'(bus_a.mem_adr), 32'h20);
      chk("boot_dbg_rdata", 32'(bus_a.dbg_rdata), 32'h44);
      cyc();
      bus_a.cpu_memwrite = 1'b0; bus_a.cpu_memread = 1'b1;
      neg(); chk("cpu_rd", 32'(bus_a.cpu_rdata), 32'h5A); cyc();

      // CPU and debug collide: CPU wins, debug served next idle cycle
      bus_a.dbg_req = 1'b1; bus_a.dbg_adr = 8'h01;
      neg(); chk("collide_gnt", 32'(bus_a.dbg_gnt), 32'd0); cyc();
      bus_a.cpu_memread = 1'b0;
      neg(); chk("idle_gnt", 32'(bus_a.dbg_gnt), 32'd1); cyc();
      bus_a.dbg_req = 1'b0;
      neg();
      chk("dbg_rvalid", 32'(bus_a.dbg_rvalid), 32'd1);
      chk("dbg_rdata", 32'(bus_a.dbg_rdata), 32'h22);
      cyc();

      // Debug write then CPU read-back
      bus_a.dbg_req = 1'b1; bus_a.dbg_we = 1'b1; bus_a.dbg_adr = 8'h30; bus_a.dbg_wdata = 8'h77;
      neg(); chk("dbg_wr_we", 32'(bus_a.mem_we), 32'd1); cyc();
      bus_a.dbg_req = 1'b0; bus_a.dbg_we = 1'b0;
      bus_a.cpu_memread = 1'b1; bus_a.cpu_adr = 8'h30;
      neg();
      chk("dbg_wr_readback", 32'(bus_a.cpu_rdata), 32'h77);
      chk("dbg_wr_no_rvalid", 32'(bus_a.dbg_rvalid), 32'd0);
      cyc();

      // Back-to-back debug reads
      bus_a.cpu_memread = 1'b0;
      bus_a.dbg_req = 1'b1; bus_a.dbg_adr = 8'h02;
      neg(); chk("b2b_gnt0", 32'(bus_a.dbg_gnt), 32'd1); cyc();
      bus_a.dbg_adr = 8'h00;
      neg();
      chk("b2b_gnt1", 32'(bus_a.dbg_gnt), 32'd1);
      chk("b2b_rdata0", 32'(bus_a.dbg_rdata), 32'h33);
      cyc();
      bus_a.dbg_req = 1'b0;
      neg(); chk("b2b_rdata1", 32'(bus_a.dbg_rdata), 32'h11); cyc();

      // Reset partway through a reload, then a full reload
      reset_a = 1'b1;
      neg(); cyc();
      reset_a = 1'b0;
      boot_a(8'hB0);
      boot_a(8'hB1);
      reset_a = 1'b1;
      neg();
      chk("midrst_cpu_reset", 32'(bus_a.cpu_reset), 32'd1);
      chk("midrst_mem_we", 32'(bus_a.mem_we), 32'd0);
      cyc();
      reset_a = 1'b0;
      for (int i = 0; i < 4; i++) boot_a(8'hA0 + 8'(i));
      neg(); chk("reload_rel_done", 32'(bus_a.boot_done), 32'd0); cyc();
      neg();
      chk("reload_done", 32'(bus_a.boot_done), 32'd1);
      chk("reload_mem0", 32'(mem_a[0]), 32'hA0);
      chk("reload_mem1", 32'(mem_a[1]), 32'hA1);
      chk("reload_mem2", 32'(mem_a[2]), 32'hA2);
      chk("reload_mem3", 32'(mem_a[3]), 32'hA3);
      cyc();

      // Full 256-byte load on instance B
      neg();
      chk("b_rst_cpu_reset", 32'(bus_b.cpu_reset), 32'd1);
      chk("b_rst_boot_ready", 32'(bus_b.boot_ready), 32'd0);
      chk("b_rst_mem_we", 32'(bus_b.mem_we), 32'd0);
      cyc();
      reset_b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bus_b.boot_valid = 1'b1;
         bus_b.boot_data = 8'(i) ^ 8'hA5;
         cyc();
      end
      bus_b.boot_valid = 1'b0;
      neg(); chk("b_rel_cpu_reset", 32'(bus_b.cpu_reset), 32'd1); cyc();
      neg();
      chk("b_run_cpu_reset", 32'(bus_b.cpu_reset), 32'd0);
      chk("b_boot_done", 32'(bus_b.boot_done), 32'd1);
      cyc();
      for (int i = 0; i < 4; i++) cyc();
      chk("b_mem00", 32'(mem_b[0]), 32'hA5);
      chk("b_mem80", 32'(mem_b[128]), 32'h25);
      chk("b_memff", 32'(mem_b[255]), 32'h5A);
      chk("b_release_once", 32'(rel_b), 32'd1);
      chk("b_no_wrap", 32'(wr0_b), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
